// File: rtl/flash_ctrl_pkg.sv
// Encodings and address geometry shared by the flash controller erase path and the
// flash-side erase responder.
package flash_ctrl_pkg;

  typedef enum logic {
    PageErase = 1'b0,
    BankErase = 1'b1
  } erase_op_e;

  typedef enum logic [1:0] {
    FlashRead  = 2'd0,
    FlashProg  = 2'd1,
    FlashErase = 2'd2
  } flash_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StSettle,
    StResp,
    StWaitRel
  } erase_st_e;

  localparam int DefWordsPerPage = 16;
  localparam int DefPagesPerBank = 32;
  localparam int WordsBitWidth   = $clog2(DefWordsPerPage);
  localparam int PagesBitWidth   = $clog2(DefPagesPerBank);
  localparam int DefAddrW        = 1 + PagesBitWidth + WordsBitWidth;

  localparam logic [DefAddrW-1:0] PageAddrMask = DefAddrW'((1 << WordsBitWidth) - 1);
  localparam logic [DefAddrW-1:0] BankAddrMask =
    DefAddrW'((1 << (WordsBitWidth + PagesBitWidth)) - 1);

  // Any address bit inside the masked region makes the base unusable.
  function automatic logic addr_misaligned(input logic [31:0] addr, input logic [31:0] mask);
    return |(addr & mask);
  endfunction

endpackage

// File: rtl/flash_erase_rsp.sv
// Flash-side erase responder: checks alignment, writes the erased value across a page
// or bank, waits a settle interval and returns a single done or error pulse.
module flash_erase_rsp
  import flash_ctrl_pkg::*;
#(
  parameter int AddrW         = 10,
  parameter int WordsPerPage  = 16,
  parameter int PagesPerBank  = 32,
  parameter int DataW         = 16,
  parameter int SettleCycles  = 4,
  parameter int EraseBitWidth = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic [AddrW-1:0]         addr_i,
  input  logic [EraseBitWidth-1:0] op_i,
  output logic                     done_o,
  output logic                     error_o,
  output logic                     busy_o,
  output logic                     mem_we_o,
  output logic [AddrW-1:0]         mem_addr_o,
  output logic [DataW-1:0]         mem_wdata_o
);

  localparam int WordsBits = $clog2(WordsPerPage);
  localparam int PagesBits = $clog2(PagesPerBank);
  localparam int CntW      = $clog2(WordsPerPage * PagesPerBank) + 1;
  localparam int SetW      = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

  localparam logic [CntW-1:0]  PageLast   = CntW'(WordsPerPage - 1);
  localparam logic [CntW-1:0]  BankLast   = CntW'(WordsPerPage * PagesPerBank - 1);
  localparam logic [SetW-1:0]  SettleLast = SetW'(SettleCycles - 1);
  localparam logic [31:0]      PageMask   = 32'((1 << WordsBits) - 1);
  localparam logic [31:0]      BankMask   = 32'((1 << (WordsBits + PagesBits)) - 1);

  erase_st_e        state_q, state_d;
  logic [AddrW-1:0] base_q;
  logic             bank_q;
  logic             err_q;
  logic [CntW-1:0]  cnt_q;
  logic [SetW-1:0]  scnt_q;
  logic             is_bank;
  logic             misaligned;
  logic [CntW-1:0]  last_word;

  assign is_bank    = (op_i == EraseBitWidth'(BankErase));
  assign misaligned = addr_misaligned(32'(addr_i), is_bank ? BankMask : PageMask);
  assign last_word  = bank_q ? BankLast : PageLast;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_i) state_d = misaligned ? StResp : StErase;
      StErase:   if (cnt_q == last_word) state_d = (SettleCycles == 0) ? StResp : StSettle;
      StSettle:  if (scnt_q == SettleLast) state_d = StResp;
      StResp:    state_d = StWaitRel;
      StWaitRel: if (!req_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Request fields are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q <= '0;
      bank_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      scnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (req_i) begin
          base_q <= addr_i;
          bank_q <= is_bank;
          err_q  <= misaligned;
          cnt_q  <= '0;
          scnt_q <= '0;
        end
        StErase:  cnt_q  <= cnt_q + 1'b1;
        StSettle: scnt_q <= scnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs are registered copies of the state, so they trail it by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      busy_o      <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      done_o      <= (state_q == StResp) && !err_q;
      error_o     <= (state_q == StResp) && err_q;
      busy_o      <= (state_d != StIdle);
      mem_we_o    <= (state_q == StErase);
      mem_addr_o  <= (state_q == StErase) ? base_q + AddrW'(cnt_q) : '0;
      mem_wdata_o <= {DataW{state_q == StErase}};
    end
  end

endmodule

// File: tb/tb_flash_erase_rsp.sv
// Directed bench for flash_erase_rsp: expected write addresses go to a scoreboard
// queue at request time and are popped as the array write port fires.
module tb_flash_erase_rsp;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [9:0] addr;
  logic [0:0] op;
  logic       done_o, error_o, busy_o, mem_we_o;
  logic [9:0] mem_addr_o;
  logic [15:0] mem_wdata_o;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;
  logic [9:0] exp_q[$];

  flash_erase_rsp #(
    .AddrW(10), .WordsPerPage(16), .PagesPerBank(32), .DataW(16),
    .SettleCycles(SETTLE), .EraseBitWidth(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .op_i(op),
    .done_o(done_o), .error_o(error_o), .busy_o(busy_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Array-side monitor: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we_o) begin
        if (exp_q.size() == 0) chk("spurious_we", 32'(mem_we_o), 32'd0);
        else begin
          logic [9:0] ea;
          ea = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr_o), 32'(ea));
          chk("wr_data", 32'(mem_wdata_o), 32'hFFFF);
        end
      end else chk("idle_wdata", 32'(mem_wdata_o), 32'd0);
      chk("done_err_excl", 32'(done_o & error_o), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic run_erase(input logic [9:0] a, input logic o, input bit exp_err,
                           input int drop_at, input int hold_after);
    int n, done_cyc;
    n = o ? 512 : 16;
    done_cyc = exp_err ? 1 : n + SETTLE + 1;
    @(posedge clk); #1;
    req = 1'b1; addr = a; op = o;
    if (!exp_err) for (int i = 0; i < n; i++) exp_q.push_back(a + 10'(i));
    @(posedge clk);                       // acceptance edge (cycle 0)
    #1 addr = ~a; op = ~o;                // must be ignored from here on
    for (int k = 1; k <= done_cyc; k++) begin
      @(posedge clk);
      if (k == drop_at) #1 req = 1'b0;
      @(negedge clk);
      chk("we",    32'(mem_we_o), 32'(!exp_err && k <= n));
      chk("done",  32'(done_o),   32'(!exp_err && k == done_cyc));
      chk("error", 32'(error_o),  32'(exp_err && k == done_cyc));
      chk("busy",  32'(busy_o),   32'd1);
    end
    for (int h = 0; h < hold_after; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_we",   32'(mem_we_o), 32'd0);
      chk("hold_done", 32'(done_o | error_o), 32'd0);
      chk("hold_busy", 32'(busy_o), 32'd1);
    end
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rel_busy", 32'(busy_o), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done",  32'(done_o),      32'd0);
    chk("rst_error", 32'(error_o),     32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    chk("rst_we",    32'(mem_we_o),    32'd0);
    chk("rst_addr",  32'(mem_addr_o),  32'd0);
    chk("rst_wdata", 32'(mem_wdata_o), 32'd0);
    rst_n = 1'b1; mon_en = 1'b1;

    run_erase(10'h030, 1'b0, 1'b0, 0, 5);   // page erase, request held after done
    run_erase(10'h0A0, 1'b0, 1'b0, 0, 0);   // re-raised request accepted
    run_erase(10'h200, 1'b1, 1'b0, 0, 0);   // bank 1 erase
    run_erase(10'h031, 1'b0, 1'b1, 0, 2);   // misaligned page
    run_erase(10'h210, 1'b1, 1'b1, 0, 0);   // misaligned bank
    run_erase(10'h100, 1'b0, 1'b0, 3, 0);   // request dropped mid-erase

    // reset lands on edge 8 of a page erase
    @(posedge clk); #1;
    req = 1'b1; addr = 10'h040; op = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(10'h040 + 10'(i));
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); @(negedge clk);
      chk("pre_rst_we", 32'(mem_we_o), 32'd1);
    end
    rst_n = 1'b0; req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_we",    32'(mem_we_o),    32'd0);
    chk("mid_rst_done",  32'(done_o),      32'd0);
    chk("mid_rst_busy",  32'(busy_o),      32'd0);
    chk("mid_rst_addr",  32'(mem_addr_o),  32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata_o), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_quiet", 32'({done_o, error_o, busy_o, mem_we_o}), 32'd0);
    end

    run_erase(10'h3F0, 1'b0, 1'b0, 0, 0);   // last page of the array after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/flash_erase_rsp.md
# flash_erase_rsp

Flash-side responder for erase requests issued by the flash controller's erase path. Accepts a level-held request (address + erase type), checks alignment, sweeps the target page or bank writing the erased value word by word into the flash memory model's write port, waits a settle interval, then returns a one-cycle done or error pulse. Sits between the controller's erase request interface and the flash array.

## Interface
- AddrW, 10: word address width (1 bank bit + PagesBitWidth + WordsBitWidth)
- WordsPerPage, 16: words per page, power of two
- PagesPerBank, 32: pages per bank, power of two
- DataW, 16: flash word width
- SettleCycles, 4: idle cycles after the last write before done; 0 allowed
- EraseBitWidth, 1: width of op_i

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- req_i  in  1  erase request; held high by initiator until done_o/error_o seen
- addr_i  in  AddrW  base word address
- op_i  in  EraseBitWidth  0 = PageErase, 1 = BankErase
- done_o  out  1  one-cycle pulse: erase complete
- error_o  out  1  one-cycle pulse: request rejected (misaligned)
- busy_o  out  1  high in every state except IDLE
- mem_we_o  out  1  array write strobe
- mem_addr_o  out  AddrW  array write address
- mem_wdata_o  out  DataW  always all-ones when mem_we_o high, else 0

## Operation
- States: IDLE, ERASE, SETTLE, RESP, WAIT_REL.
- IDLE: on req_i=1, latch addr_i and op_i. Misaligned (PageErase with addr_i[WordsBitWidth-1:0]≠0; BankErase with addr_i[PagesBitWidth+WordsBitWidth-1:0]≠0) → RESP with error flag; else → ERASE, word counter=0.
- ERASE: mem_we_o=1, mem_addr_o=base+counter; counter increments each cycle. Count N = WordsPerPage (page) or WordsPerPage*PagesPerBank (bank). After write N-1 → SETTLE (or RESP if SettleCycles=0).
- SETTLE: count SettleCycles cycles, then → RESP.
- RESP: done_o=1 (or error_o=1), exactly one cycle; → WAIT_REL.
- WAIT_REL: stay until req_i=0, then → IDLE. Prevents re-accepting a request still held in the cycle after the response.
- addr_i/op_i changes after acceptance are ignored. req_i dropping mid-operation does not abort; sequence completes, pulse still issued, WAIT_REL then exits immediately.
- Counter width: $clog2(WordsPerPage*PagesPerBank)+1 bits; addition base+counter truncated to AddrW (cannot wrap for aligned bases).
- done_o and error_o never both high.

## Timing
- Reset (rst_ni low at an edge): state IDLE, all outputs 0, counters 0. Reset mid-erase leaves array partially erased; no pulse issued.
- Acceptance edge = cycle 0. Writes in cycles 1..N; SETTLE cycles N+1..N+SettleCycles; done_o in cycle N+SettleCycles+1.
- Error: error_o in cycle 1, no mem_we_o.
- Earliest next acceptance: first edge after req_i seen low in WAIT_REL.
- All outputs registered from state/counters; no combinational path from req_i to any output.

## Structure
- Shared flash_ctrl_pkg: erase op encoding (PageErase=0, BankErase=1), flash op encoding (FlashRead/Prog/Erase), WordsBitWidth/PagesBitWidth derivations, page/bank address masks — same definitions the controller's erase path uses.
- Single module, one FSM plus word and settle counters; no sub-module.

## Test plan
- Page erase, addr_i=0x030, op=0, SettleCycles=4: writes 0x030..0x03F in cycles 1..16 with wdata 0xFFFF, done_o in cycle 21 only.
- Bank erase, addr_i=0x200, op=1: 512 writes 0x200..0x3FF, done_o cycle 517; no write outside bank 1.
- Misaligned: page erase addr_i=0x031 → error_o cycle 1, no writes; bank erase addr_i=0x210 → error_o cycle 1.
- Held request: req_i kept high 5 cycles after done_o → no second erase; drop req_i, re-raise → new erase accepted.
- Reset mid-erase: rst_ni low at cycle 8 of page erase → next cycle all outputs 0, state IDLE; no done_o.
- req_i dropped in cycle 3 of page erase → all 16 writes still occur, done_o pulses, returns to IDLE.
